spi_slave_regfile: RTL and testbench

//  SPI slave (mode 0: CPOL=0, CPHA=0, MSB first) responding to the simple_spi master's sck_o/mosi_o/miso_i pins.

---
 rtl/spi_slave_regfile.sv | 175 +++++++++++++++++
 tb/tb_spi_slave_regfile.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regfile.sv
// -----------------------------------------------------------------------------
// spi_slave_regfile
//   SPI mode-0 slave (CPOL=0, CPHA=0, MSB first) fronting a small byte register
//   file. Frame: byte0 = {rw, unused, addr}, byte1 = data. For a write the data
//   byte is committed to reg[addr]. For a read, reg[addr] is shifted out on miso
//   during byte1. miso carries ID_BYTE during byte0. All SPI pins are
//   oversampled in the clk_i domain; nothing is clocked by sck.
//
//   Optional feature: define SPI_SLAVE_AUTOINC_EN for burst frames. Each further
//   data byte advances addr (mod NREG) and is again a write or a read.
//
// Ports
//   clk_i, rst_i          system clock, async active-high reset
//   sck_i, ss_n_i, mosi_i SPI inputs (asynchronous to clk_i)
//   miso_o, miso_oe_o     SPI output data and its output enable
//   regs_o                flat register file, reg[n] at [8n+7:8n]
//   wr_stb_o              one-clk pulse per committed write
//   wr_addr_o, wr_data_o  address/data of the committed write
// -----------------------------------------------------------------------------
module spi_slave_regfile #(
    parameter int         ADDR_W  = 3,
    parameter logic [7:0] ID_BYTE = 8'hA5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      sck_i,
    input  logic                      ss_n_i,
    input  logic                      mosi_i,
    output logic                      miso_o,
    output logic                      miso_oe_o,
    output logic [8*(2**ADDR_W)-1:0]  regs_o,
    output logic                      wr_stb_o,
    output logic [ADDR_W-1:0]         wr_addr_o,
    output logic [7:0]                wr_data_o
);
    localparam int NREG = 2**ADDR_W;

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;
    state_t r_state, w_state_nxt;

    logic [2:0]            r_sck_s;
    logic [2:0]            r_ss_s;
    logic [1:0]            r_mosi_s;
    logic [2:0]            r_cnt;
    logic [7:0]            r_rx;
    logic [7:0]            r_tx;
    logic                  r_rw;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_pend_cmd;
    logic                  r_pend_data;
    logic [NREG-1:0][7:0]  r_regs;
    logic                  r_wr_stb;
    logic [ADDR_W-1:0]     r_wr_addr;
    logic [7:0]            r_wr_data;

    logic w_sck_rise, w_sck_fall, w_ss_n, w_ss_fall, w_mosi, w_active, w_byte_end;

    // Two-flop synchronisers. sck and ss_n carry a third flop for edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sck_s  <= 3'b000;
            r_ss_s   <= 3'b111;
            r_mosi_s <= 2'b00;
        end else begin
            r_sck_s  <= {r_sck_s[1:0], sck_i};
            r_ss_s   <= {r_ss_s[1:0], ss_n_i};
            r_mosi_s <= {r_mosi_s[0], mosi_i};
        end
    end

    assign w_sck_rise = r_sck_s[1] & ~r_sck_s[2];
    assign w_sck_fall = ~r_sck_s[1] & r_sck_s[2];
    assign w_ss_n     = r_ss_s[1];
    assign w_ss_fall  = ~r_ss_s[1] & r_ss_s[2];
    assign w_mosi     = r_mosi_s[1];
    assign w_active   = (r_state == S_CMD) || (r_state == S_DATA);
    // Deselect wins over a coincident 8th rise, so an aborted byte never completes.
    assign w_byte_end = w_active & w_sck_rise & (r_cnt == 3'd7) & ~w_ss_n;

`ifdef SPI_SLAVE_AUTOINC_EN
    logic [ADDR_W-1:0] w_addr_inc;
    assign w_addr_inc = r_addr + ADDR_W'(1);
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        miso_o      = 1'b0;
        miso_oe_o   = 1'b0;
        if (w_ss_n) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_ss_fall)  w_state_nxt = S_CMD;
                S_CMD:  if (w_byte_end) w_state_nxt = S_DATA;
                S_DATA: begin
`ifdef SPI_SLAVE_AUTOINC_EN
                    w_state_nxt = S_DATA;
`else
                    if (w_byte_end) w_state_nxt = S_DONE;
`endif
                end
                default: w_state_nxt = r_state;
            endcase
        end
        if (r_state != S_IDLE) miso_oe_o = 1'b1;
        if (w_active)          miso_o    = r_tx[7];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt       <= 3'd0;
            r_rx        <= 8'h00;
            r_tx        <= 8'h00;
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_pend_cmd  <= 1'b0;
            r_pend_data <= 1'b0;
            r_regs      <= '0;
            r_wr_stb    <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= 8'h00;
        end else begin
            r_wr_stb    <= 1'b0;
            r_pend_cmd  <= w_byte_end && (r_state == S_CMD);
            r_pend_data <= w_byte_end && (r_state == S_DATA);

            if (w_ss_n || (r_state == S_IDLE)) begin
                r_cnt <= 3'd0;
            end else if (w_sck_rise) begin
                r_cnt <= r_cnt + 3'd1;
                r_rx  <= {r_rx[6:0], w_mosi};
            end

            // Transmit byte: ID on select, then the response byte one clk after a
            // byte boundary. Falls shift, except the fall right after a boundary
            // (r_cnt==0), which must leave the freshly loaded MSB on the wire.
            if ((r_state == S_IDLE) && w_ss_fall) begin
                r_tx <= ID_BYTE;
            end else if (r_pend_cmd) begin
                r_rw   <= r_rx[7];
                r_addr <= r_rx[ADDR_W-1:0];
                r_tx   <= r_rx[7] ? r_regs[r_rx[ADDR_W-1:0]] : 8'h00;
            end else if (r_pend_data) begin
`ifdef SPI_SLAVE_AUTOINC_EN
                r_addr <= w_addr_inc;
                r_tx   <= r_rw ? r_regs[w_addr_inc] : 8'h00;
`else
                r_tx   <= 8'h00;
`endif
            end else if (w_active && w_sck_fall && (r_cnt != 3'd0)) begin
                r_tx <= {r_tx[6:0], 1'b0};
            end

            // A data byte that completed while selected is committed even if
            // ss_n rises in the following clock.
            if (r_pend_data && !r_rw) begin
                r_regs[r_addr] <= r_rx;
                r_wr_stb       <= 1'b1;
                r_wr_addr      <= r_addr;
                r_wr_data      <= r_rx;
            end
        end
    end

    assign regs_o    = r_regs;
    assign wr_stb_o  = r_wr_stb;
    assign wr_addr_o = r_wr_addr;
    assign wr_data_o = r_wr_data;

endmodule

// File: tb/tb_spi_slave_regfile.sv
`timescale 1ns/1ps
module tb_spi_slave_regfile;
    localparam int         ADDR_W = 3;
    localparam int         NREG   = 8;
    localparam int         HALF   = 8;   // clk cycles per sck half period (f_clk/16)
    localparam int         SETUP  = 8;   // clk cycles from ss_n fall to first bit
    localparam int         GAP    = 12;
    localparam logic [7:0] ID     = 8'hA5;
`ifdef SPI_SLAVE_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1, sck = 1'b0, ss_n = 1'b1, mosi = 1'b0;
    logic              miso, miso_oe, wr_stb;
    logic [8*NREG-1:0] regs;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    always #5 clk = ~clk;

    spi_slave_regfile #(.ADDR_W(ADDR_W), .ID_BYTE(ID)) dut (
        .clk_i(clk), .rst_i(rst), .sck_i(sck), .ss_n_i(ss_n), .mosi_i(mosi),
        .miso_o(miso), .miso_oe_o(miso_oe), .regs_o(regs),
        .wr_stb_o(wr_stb), .wr_addr_o(wr_addr), .wr_data_o(wr_data));

    int n_cmp = 0, n_err = 0;
    logic [7:0]         model [NREG];
    logic [ADDR_W+7:0]  exp_wr[$];
    logic [7:0]         fbytes[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_vec();
        logic [63:0] v = '0;
        for (int i = 0; i < NREG; i++) v[8*i +: 8] = model[i];
        return v;
    endfunction

    // Scoreboard monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (wr_stb === 1'b1) begin
            if (exp_wr.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_wr_stb: got addr=%0d data=%h expected no strobe", wr_addr, wr_data);
            end else begin
                chk("wr_stb_addr_data", 64'({wr_addr, wr_data}), 64'(exp_wr.pop_front()));
            end
        end
    end

    // Mode-0 master: drive mosi while sck low, sample miso just before the rise.
    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = tx[i];
            repeat (HALF) @(negedge clk);
            rx[i] = miso;
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    // Complete bytes follow the frame rules; a trailing partial byte must be ignored.
    task automatic run_frame(input int nbytes, input int part_bits);
        logic [7:0] rx, exp;
        logic       rw;
        int         addr, a;
        rw   = fbytes[0][7];
        addr = int'(fbytes[0][ADDR_W-1:0]);
        ss_n = 1'b0;
        repeat (SETUP) @(negedge clk);
        chk("miso_oe_selected", 64'(miso_oe), 64'(1));
        for (int k = 0; k < nbytes; k++) begin
            exp = 8'h00;
            if (k == 0) begin
                exp = ID;
            end else if (AUTOINC || k == 1) begin
                a = (addr + k - 1) % NREG;
                if (rw) exp = model[a];
                else begin
                    model[a] = fbytes[k];
                    exp_wr.push_back({ADDR_W'(a), fbytes[k]});
                end
            end
            spi_xfer(fbytes[k], 8, rx);
            chk($sformatf("miso_byte%0d", k), 64'(rx), 64'(exp));
        end
        if (part_bits > 0) spi_xfer(8'($urandom), part_bits, rx);
        repeat (HALF) @(negedge clk);
        ss_n = 1'b1;
        repeat (GAP) @(negedge clk);
        chk("miso_oe_idle", 64'(miso_oe), 64'(0));
        chk("miso_idle", 64'(miso), 64'(0));
        chk("regs", regs, model_vec());
    endtask

    initial begin
        logic [7:0] rx;
        int nb, pb;
        for (int i = 0; i < NREG; i++) model[i] = 8'h00;
        repeat (4) @(negedge clk);
        chk("reset_regs", regs, 64'(0));
        chk("reset_miso_oe", 64'(miso_oe), 64'(0));
        chk("reset_miso", 64'(miso), 64'(0));
        chk("reset_wr_stb", 64'(wr_stb), 64'(0));
        chk("reset_wr_addr_data", 64'({wr_addr, wr_data}), 64'(0));
        rst = 1'b0;
        repeat (GAP) @(negedge clk);

        fbytes = '{8'h03, 8'h5C, 8'h00, 8'h00}; run_frame(2, 0);   // write
        fbytes = '{8'h83, 8'hFF, 8'h00, 8'h00}; run_frame(2, 0);   // read back
        fbytes = '{8'h02, 8'hFF, 8'h00, 8'h00};                     // abort after 5 bits
        ss_n = 1'b0;
        repeat (SETUP) @(negedge clk);
        spi_xfer(8'h02, 8, rx);
        chk("abort_miso_id", 64'(rx), 64'(ID));
        spi_xfer(8'hFF, 5, rx);
        repeat (HALF) @(negedge clk);
        ss_n = 1'b1;
        repeat (GAP) @(negedge clk);
        chk("abort_regs", regs, model_vec());
        fbytes = '{8'h02, 8'h11, 8'h00, 8'h00}; run_frame(2, 0);
        fbytes = '{8'h06, 8'hAA, 8'hBB, 8'hCC}; run_frame(4, 0);   // burst / DONE

        // Async reset in the middle of the data byte of a write.
        ss_n = 1'b0;
        repeat (SETUP) @(negedge clk);
        spi_xfer(8'h05, 8, rx);
        chk("t6_miso_id", 64'(rx), 64'(ID));
        spi_xfer(8'h77, 4, rx);
        rst = 1'b1;
        #1;
        chk("t6_regs_reset", regs, 64'(0));
        chk("t6_miso_oe_reset", 64'(miso_oe), 64'(0));
        chk("t6_miso_reset", 64'(miso), 64'(0));
        chk("t6_wr_stb_reset", 64'(wr_stb), 64'(0));
        for (int i = 0; i < NREG; i++) model[i] = 8'h00;
        ss_n = 1'b1;
        sck  = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (GAP) @(negedge clk);
        fbytes = '{8'h05, 8'h77, 8'h00, 8'h00}; run_frame(2, 0);

        for (int f = 0; f < 30; f++) begin
            for (int k = 0; k < 4; k++) fbytes[k] = 8'($urandom);
            nb = $urandom_range(1, 4);
            pb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            if ($urandom_range(0, 3) == 0) begin
                // sck activity while deselected must be ignored
                for (int t = 0; t < 6; t++) begin
                    mosi = 1'($urandom);
                    sck  = ~sck;
                    repeat (HALF) @(negedge clk);
                end
                repeat (GAP) @(negedge clk);
            end
            run_frame(nb, pb);
        end

        repeat (GAP) @(negedge clk);
        chk("pending_wr_stb", 64'(exp_wr.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
